// File: rtl/interp_sample_feeder_pkg.sv
// Shared types and constants for the interpolation reference-sample feeder.
// Holds the line geometry, window size, FSM encoding and a clamp helper.
package interp_sample_feeder_pkg;

    localparam int SAMPLE_W = 8;
    localparam int WIN      = 9;
    localparam int LINE_W   = SAMPLE_W * WIN;
    localparam int PRE_TAPS = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [LINE_W-1:0] data;
    } line_t;

    function automatic logic signed [9:0] clamp10(
        input logic signed [9:0] v,
        input logic signed [9:0] lo,
        input logic signed [9:0] hi
    );
        if (v < lo)
            return lo;
        if (v > hi)
            return hi;
        return v;
    endfunction

endpackage

// File: rtl/interp_sample_feeder_line_fifo.sv
// Two-entry line FIFO carrying one sample line plus its last-line tag.
// Push and pop may coincide; the producer guarantees it never overflows.
module line_fifo_2
    import interp_sample_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  line_t      din,
    output line_t      dout,
    output logic [1:0] count
);

    line_t      mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop)
                rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/interp_sample_feeder.sv
// Fetches the 9x9 integer reference window of a 4x4 block, one clamped
// row per read, and streams the rows out through a two-line buffer.
module interp_sample_feeder
    import interp_sample_feeder_pkg::*;
#(
    parameter int FRAME_WIDTH  = 64,
    parameter int FRAME_HEIGHT = 64,
    parameter int ADDR_W       = 12,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic              CLK,
    input  logic              RST_ASYNC,
    input  logic              START,
    input  logic [6:0]        BLK_X,
    input  logic [6:0]        BLK_Y,
    input  logic [7:0]        INT_MV_X,
    input  logic [7:0]        INT_MV_Y,
    output logic              MEM_RD_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [LINE_W-1:0] MEM_RD_DATA,
    output logic              LINE_VALID,
    input  logic              LINE_READY,
    output logic [LINE_W-1:0] INTEGER_SAMPLES,
    output logic              LINE_LAST,
    output logic              BUSY,
    output logic              DONE
);

    state_t            state;
    state_t            state_nx;
    logic signed [9:0] bx_s, by_s, mx_s, my_s;
    logic signed [9:0] ox_raw, oy_raw;
    logic signed [9:0] ox_q, oy_q, yr;
    logic [3:0]        row_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic              pop;
    logic              issue_ok;
    logic              last_row;
    logic              rd_en;
    line_t             head;
    line_t             push_line;

    assign bx_s   = {3'b000, BLK_X};
    assign by_s   = {3'b000, BLK_Y};
    assign mx_s   = {{2{INT_MV_X[7]}}, INT_MV_X};
    assign my_s   = {{2{INT_MV_Y[7]}}, INT_MV_Y};
    assign ox_raw = bx_s + mx_s - 10'(PRE_TAPS);
    assign oy_raw = by_s + my_s - 10'(PRE_TAPS);

    assign yr = clamp10(oy_q + 10'(row_q), 10'sd0,
                        10'(FRAME_HEIGHT - 1));

    assign LINE_VALID = (fifo_cnt != 2'd0);
    assign pop        = LINE_VALID & LINE_READY;
    assign last_row   = (row_q == 4'(WIN - 1));

    // Lines already buffered or on their way must leave room after pop.
    assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign issue_ok = occ < (3'(FIFO_DEPTH) + {2'b00, pop});

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (START) state_nx = S_FETCH;
            S_FETCH: if (issue_ok && last_row) state_nx = S_DRAIN;
            S_DRAIN: if (pop && head.last && fifo_cnt == 2'd1 &&
                         !inflight_q)
                         state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (state == S_FETCH) && issue_ok;
        MEM_RD_EN = rd_en;
        MEM_ADDR  = '0;
        if (rd_en)
            MEM_ADDR = ADDR_W'(yr) * ADDR_W'(FRAME_WIDTH) +
                       ADDR_W'(ox_q);
        BUSY = (state != S_IDLE);
        DONE = (state == S_DONE);
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            ox_q            <= '0;
            oy_q            <= '0;
            row_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (state == S_IDLE && START) begin
                ox_q  <= clamp10(ox_raw, 10'sd0,
                                 10'(FRAME_WIDTH - WIN));
                oy_q  <= oy_raw;
                row_q <= '0;
            end else if (rd_en) begin
                row_q <= row_q + 4'd1;
            end
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & last_row;
        end
    end

    assign push_line.last = inflight_last_q;
    assign push_line.data = MEM_RD_DATA;

    line_fifo_2 u_fifo (
        .clk   (CLK),
        .rst   (RST_ASYNC),
        .push  (inflight_q),
        .pop   (pop),
        .din   (push_line),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign INTEGER_SAMPLES = LINE_VALID ? head.data : '0;
    assign LINE_LAST       = LINE_VALID & head.last;

endmodule

// File: tb/tb_interp_sample_feeder.sv
// Directed and randomized bench for the reference-sample feeder,
// checked against a plain-arithmetic window/address model.
module tb_interp_sample_feeder;

    localparam int FW = 64;
    localparam int FH = 64;

    logic        CLK;
    logic        RST_ASYNC;
    logic        START;
    logic [6:0]  BLK_X, BLK_Y;
    logic [7:0]  INT_MV_X, INT_MV_Y;
    logic        MEM_RD_EN;
    logic [11:0] MEM_ADDR;
    logic [71:0] MEM_RD_DATA;
    logic        LINE_VALID;
    logic        LINE_READY;
    logic [71:0] INTEGER_SAMPLES;
    logic        LINE_LAST;
    logic        BUSY;
    logic        DONE;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] salt = 32'h0;

    int          addr_q[$];
    int          rd_cyc[$];
    logic [71:0] line_q[$];
    logic        last_q[$];
    int          ln_cyc[$];

    interp_sample_feeder #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .ADDR_W      (12),
        .FIFO_DEPTH  (2)
    ) dut (
        .CLK            (CLK),
        .RST_ASYNC      (RST_ASYNC),
        .START          (START),
        .BLK_X          (BLK_X),
        .BLK_Y          (BLK_Y),
        .INT_MV_X       (INT_MV_X),
        .INT_MV_Y       (INT_MV_Y),
        .MEM_RD_EN      (MEM_RD_EN),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_RD_DATA    (MEM_RD_DATA),
        .LINE_VALID     (LINE_VALID),
        .LINE_READY     (LINE_READY),
        .INTEGER_SAMPLES(INTEGER_SAMPLES),
        .LINE_LAST      (LINE_LAST),
        .BUSY           (BUSY),
        .DONE           (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [71:0] mem_word(input int a);
        return {salt, 28'h0, 12'(a)};
    endfunction

    // Reference frame memory: one-cycle read latency.
    always @(posedge CLK)
        if (MEM_RD_EN)
            MEM_RD_DATA <= mem_word(int'(MEM_ADDR));

    always @(negedge CLK) begin
        if (!RST_ASYNC) begin
            if (MEM_RD_EN) begin
                addr_q.push_back(int'(MEM_ADDR));
                rd_cyc.push_back(cyc);
            end
            if (LINE_VALID && LINE_READY) begin
                line_q.push_back(INTEGER_SAMPLES);
                last_q.push_back(LINE_LAST);
                ln_cyc.push_back(cyc);
            end
        end
    end

    function automatic int exp_addr(input int bx, by, mx, my, r);
        int ox, y;
        ox = bx + mx - 2;
        if (ox < 0) ox = 0;
        if (ox > FW - 9) ox = FW - 9;
        y = by + my - 2 + r;
        if (y < 0) y = 0;
        if (y > FH - 1) y = FH - 1;
        return (y * FW + ox) % 4096;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rden"}, MEM_RD_EN, 1'b0);
        check({tag, "_addr"}, MEM_ADDR, 12'd0);
        check({tag, "_valid"}, LINE_VALID, 1'b0);
        check({tag, "_data"}, INTEGER_SAMPLES, 72'd0);
        check({tag, "_last"}, LINE_LAST, 1'b0);
        check({tag, "_busy"}, BUSY, 1'b0);
        check({tag, "_done"}, DONE, 1'b0);
    endtask

    // mode 0: ready high, 1: random ready, 2: backpressure,
    // 3: stray START mid-fetch, 4: reset after 4th line
    task automatic run_block(input int bx, by, mx, my, mode);
        int c0, hold, done_cyc;
        bit fin;
        addr_q.delete(); rd_cyc.delete();
        line_q.delete(); last_q.delete(); ln_cyc.delete();
        salt = $urandom;
        @(posedge CLK); #1;
        BLK_X = 7'(bx); BLK_Y = 7'(by);
        INT_MV_X = 8'(mx); INT_MV_Y = 8'(my);
        START = 1'b1;
        c0 = cyc;
        hold = 0; fin = 0; done_cyc = -1;
        for (int k = 0; k < 300 && !fin; k++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            case (mode)
                1: LINE_READY = 1'($urandom_range(0, 1));
                2: if (line_q.size() >= 1 && hold < 10) begin
                       LINE_READY = 1'b0;
                       hold++;
                   end else LINE_READY = 1'b1;
                default: LINE_READY = 1'b1;
            endcase
            if (mode == 3 && cyc == c0 + 3) begin
                START = 1'b1;
                BLK_X = 7'(bx + 17); BLK_Y = 7'(by + 23);
                INT_MV_X = 8'(mx - 9); INT_MV_Y = 8'(my + 5);
            end
            @(negedge CLK); #1;
            if (mode == 2 && LINE_READY == 1'b0) begin
                check("hold_valid", LINE_VALID, 1'b1);
                check("hold_data", INTEGER_SAMPLES,
                      mem_word(exp_addr(bx, by, mx, my, 1)));
                if (hold >= 2) check("hold_rden", MEM_RD_EN, 1'b0);
                if (hold == 10) begin
                    check("hold_issued", addr_q.size(), 3);
                    check("hold_lines", line_q.size(), 1);
                end
            end
            if (mode == 4 && line_q.size() == 4) begin
                RST_ASYNC = 1'b1;
                #1;
                check_quiet("abort");
                @(posedge CLK); #1;
                RST_ASYNC = 1'b0;
                fin = 1;
            end
            if (DONE) begin
                done_cyc = cyc;
                check("busy_at_done", BUSY, 1'b1);
                fin = 1;
            end
        end
        LINE_READY = 1'b1;
        if (mode == 4) return;
        check("done_seen", done_cyc != -1, 1'b1);
        check("addr_count", addr_q.size(), 9);
        check("line_count", line_q.size(), 9);
        for (int r = 0; r < 9 && r < addr_q.size(); r++)
            check($sformatf("addr%0d", r), addr_q[r],
                  exp_addr(bx, by, mx, my, r));
        for (int r = 0; r < 9 && r < line_q.size(); r++) begin
            check($sformatf("line%0d", r), line_q[r],
                  mem_word(exp_addr(bx, by, mx, my, r)));
            check($sformatf("last%0d", r), last_q[r], r == 8);
        end
        if (mode == 0 && rd_cyc.size() >= 1 && ln_cyc.size() == 9) begin
            check("lat_rden", rd_cyc[0], c0 + 1);
            check("lat_first_line", ln_cyc[0], c0 + 3);
            check("lat_last_line", ln_cyc[8], c0 + 11);
            check("lat_done", done_cyc, c0 + 12);
        end
        @(posedge CLK); #1;
        @(negedge CLK); #1;
        check("idle_busy", BUSY, 1'b0);
        check("idle_rden", MEM_RD_EN, 1'b0);
    endtask

    initial begin
        RST_ASYNC = 1'b1;
        START = 1'b0;
        BLK_X = '0; BLK_Y = '0;
        INT_MV_X = '0; INT_MV_Y = '0;
        LINE_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        check_quiet("reset");
        RST_ASYNC = 1'b0;
        @(negedge CLK); #1;
        check_quiet("post_reset");

        run_block(8, 8, 0, 0, 0);
        run_block(0, 0, -3, -3, 0);
        run_block(60, 60, 5, 5, 0);
        run_block(20, 30, 4, -6, 2);
        run_block(40, 12, -7, 3, 3);
        run_block(33, 44, 2, 1, 4);
        run_block(10, 50, -1, 9, 0);
        for (int i = 0; i < 6; i++)
            run_block($urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 255) - 128,
                      $urandom_range(0, 255) - 128, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interp_sample_feeder.md
Name: interp_sample_feeder

Overview:
- Supplies the interpolation datapath with its integer reference samples: one 72-bit line (9 × 8-bit samples) per handshake, 9 lines per 4x4 block.
- Computes the 9x9 window for a 4x4 block displaced by the integer MV (6-tap support: 2 samples before, 3 after).
- Reads window rows from the reference frame memory, clamping at frame edges.
- Buffers rows in a small FIFO and hands them to the interpolation control with a valid/ready handshake.

Parameters:
- FRAME_WIDTH, 64, reference frame width in samples (≥ 9).
- FRAME_HEIGHT, 64, reference frame height in samples.
- ADDR_W, 12, memory row-word address width (≥ clog2(FRAME_WIDTH*FRAME_HEIGHT)).
- FIFO_DEPTH, 2, line buffer depth (fixed 2; other values unsupported).

Ports:
- CLK  in  1  clock, rising edge.
- RST_ASYNC  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse: begin a block; sampled only in IDLE.
- BLK_X  in  7  block origin x, unsigned, in samples.
- BLK_Y  in  7  block origin y, unsigned.
- INT_MV_X  in  8  integer MV x, signed two's complement.
- INT_MV_Y  in  8  integer MV y, signed.
- MEM_RD_EN  out  1  memory read strobe.
- MEM_ADDR  out  ADDR_W  row-word address = row*FRAME_WIDTH + x.
- MEM_RD_DATA  in  72  9 samples; sample 0 in [71:64]; valid exactly 1 cycle after MEM_RD_EN.
- LINE_VALID  out  1  INTEGER_SAMPLES holds a valid line.
- LINE_READY  in  1  consumer accepts the line this cycle.
- INTEGER_SAMPLES  out  72  head-of-FIFO line.
- LINE_LAST  out  1  qualifies the 9th line of the block.
- BUSY  out  1  high from the cycle after START until DONE, inclusive.
- DONE  out  1  one-cycle pulse after the 9th line handshake.

Behaviour:
- Reset: all outputs 0; FIFO empty; in-flight flag cleared; FSM in IDLE. Reset has immediate effect mid-block; there is no partial-block resume.
- Arithmetic: signed 10-bit intermediates.
  - ox = BLK_X + INT_MV_X − 2, clamped to [0, FRAME_WIDTH−9].
  - oy = BLK_Y + INT_MV_Y − 2.
  - Row r (0..8): yr = clamp(oy + r, 0, FRAME_HEIGHT−1).
  - MEM_ADDR = yr*FRAME_WIDTH + ox, truncated to ADDR_W.
  - Operands are registered on START.
- FSM:
  - IDLE: on START, latch operands, clear row counter → FETCH. START in any other state is ignored.
  - FETCH: issue a read (MEM_RD_EN=1, row counter++) when (fifo_count + inflight − pop) < 2, where pop = LINE_VALID & LINE_READY. After row 8 is issued → DRAIN.
  - DRAIN: wait until FIFO empty, no read in flight, and the 9th line handshaken → DONE.
  - DONE: DONE=1 for one cycle → IDLE.
- Data path: MEM_RD_DATA is written into the FIFO on the cycle after MEM_RD_EN. Simultaneous push and pop is allowed. The FIFO never overflows because issue is gated.
- LINE_VALID = FIFO non-empty. INTEGER_SAMPLES and LINE_LAST hold stable while LINE_VALID & !LINE_READY.
- Latency: START at cycle 0 → MEM_RD_EN at cycle 1 → LINE_VALID at cycle 3. With LINE_READY held high: 1 line/cycle, 9 lines on cycles 3..11, DONE at cycle 12.
- LINE_LAST travels as a FIFO tag bit alongside each line.

Decomposition:
- Shared package: sample width 8, line width 72, window size 9, filter pre-taps 2, and FSM state encoding (IDLE/FETCH/DRAIN/DONE).
- One sub-module: line_fifo_2 (2-entry, 73-bit wide: data + last), with push/pop/count and asynchronous active-high reset.

Test Plan:
- Nominal: FRAME 64x64, BLK (8,8), MV (0,0), READY=1 → addresses 390, 454, …, 902 (+64 each); 9 lines; LINE_LAST on the 9th; DONE at cycle 12.
- Top-left clamp: BLK (0,0), MV (−3,−3) → ox=0; addresses 0,0,0,0,0,0,64,128,192.
- Bottom-right clamp: BLK (60,60), MV (5,5) → ox=55; all 9 addresses = 4087.
- Backpressure: READY low for 10 cycles after the first line → FIFO holds 2, MEM_RD_EN held low, lines stable; after release, 9 lines delivered in order, none lost or duplicated.
- START pulse during FETCH with different operands → ignored; the current block's addresses and line count are unchanged.
- RST_ASYNC asserted after the 4th handshake → all outputs 0 immediately; a new START then produces a full 9-line block from row 0.
